// File: rtl/int_to_float_converter_if.sv
// rtl/int_to_float_converter_if.sv - operand/result handshake bundle for the int-to-float converter
interface int_to_float_converter_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_WIDTH     = 32
);
  localparam int RESULT_W = 1 + EXPONENT_SIZE + MANTISSA_SIZE;

  logic                 in_valid;
  logic                 in_ready;
  logic [INT_WIDTH-1:0] in_int;
  logic                 out_valid;
  logic                 out_ready;
  logic [RESULT_W-1:0]  result;

  modport master (
    output in_valid, in_int, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in_int, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/int_to_float_converter.sv
// rtl/int_to_float_converter.sv - iterative signed integer to IEEE 754 converter, round-to-nearest-even
module int_to_float_converter #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  int_to_float_converter_if.slave  bus
);
  localparam int M        = MANTISSA_SIZE;
  localparam int E        = EXPONENT_SIZE;
  localparam int RESULT_W = 1 + E + M;
  localparam int NW       = $clog2(INT_WIDTH);
  localparam int BIAS     = (1 << (E - 1)) - 1;
  localparam logic [E-1:0] EXP_TOP = E'(BIAS + INT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [INT_WIDTH-1:0]  r_mag;
  logic [NW-1:0]         r_n;
  logic                  r_sign;
  logic [RESULT_W-1:0]   r_result;
  logic                  r_out_valid;

  state_t                w_state_nxt;
  logic [INT_WIDTH-1:0]  w_mag_nxt;
  logic [NW-1:0]         w_n_nxt;
  logic                  w_sign_nxt;
  logic [RESULT_W-1:0]   w_result_nxt;
  logic                  w_out_valid_nxt;
  logic                  w_in_ready;

  logic [INT_WIDTH-1:0]  w_abs;
  logic [M-1:0]          w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [M:0]            w_frac_sum;
  logic                  w_carry;
  logic [E-1:0]          w_exp;
  logic [RESULT_W-1:0]   w_packed;

  // Unsigned view keeps the most negative input representable as 2^(INT_WIDTH-1).
  assign w_abs = bus.in_int[INT_WIDTH-1] ? ((~bus.in_int) + INT_WIDTH'(1)) : bus.in_int;

  assign w_frac     = r_mag[INT_WIDTH-2 -: M];
  assign w_guard    = r_mag[INT_WIDTH-2-M];
  assign w_sticky   = |r_mag[INT_WIDTH-3-M:0];
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + (M+1)'(w_round_up);
  assign w_carry    = w_frac_sum[M];
  assign w_exp      = EXP_TOP - E'(r_n) + E'(w_carry);
  assign w_packed   = (r_mag == '0) ? '0 : {r_sign, w_exp, w_frac_sum[M-1:0]};

  always_comb begin
    w_state_nxt     = r_state;
    w_mag_nxt       = r_mag;
    w_n_nxt         = r_n;
    w_sign_nxt      = r_sign;
    w_result_nxt    = r_result;
    w_out_valid_nxt = r_out_valid;
    w_in_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_sign_nxt  = bus.in_int[INT_WIDTH-1];
          w_mag_nxt   = w_abs;
          w_n_nxt     = '0;
          w_state_nxt = (w_abs == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (!r_mag[INT_WIDTH-1]) begin
          w_mag_nxt = r_mag << 1;
          w_n_nxt   = r_n + NW'(1);
        end else begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_result_nxt    = w_packed;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mag       <= '0;
      r_n         <= '0;
      r_sign      <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mag       <= w_mag_nxt;
      r_n         <= w_n_nxt;
      r_sign      <= w_sign_nxt;
      r_result    <= w_result_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
endmodule

// File: tb/tb_int_to_float_converter.sv
// tb/tb_int_to_float_converter.sv - directed-vector self-checking bench for int_to_float_converter
module tb_int_to_float_converter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int_to_float_converter_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_WIDTH(32)) bus ();

  int_to_float_converter #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Counts edges until out_valid rises; -1 when the bound expires.
  task automatic wait_valid(output int lat, output bit ready_seen);
    lat        = -1;
    ready_seen = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bus.in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic convert(input logic [31:0] v, input logic [31:0] exp_res, input int exp_lat,
                         input string tag);
    int lat;
    bit ready_seen;
    bus.in_int   = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat, ready_seen);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_rdy"}, {31'd0, ready_seen | bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_vdrop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int          lat;
    bit          ready_seen;
    bit          unstable;
    logic [31:0] held;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_int    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    convert(32'd1,        32'h3F800000, 33, "one");
    convert(32'hFFFFFFFF, 32'hBF800000, 33, "minus_one");
    convert(32'd7,        32'h40E00000, 31, "seven");
    convert(32'h80000000, 32'hCF000000, 2,  "most_neg");
    convert(32'h01000001, 32'h4B800000, 9,  "tie_even");
    convert(32'h01000003, 32'h4B800002, 9,  "tie_up");
    convert(32'h7FFFFFFF, 32'h4F000000, 3,  "carry");
    convert(32'd0,        32'h00000000, 1,  "zero");

    // Backpressure: a new operand waits on in_valid while the result is held.
    bus.out_ready = 1'b0;
    bus.in_int    = 32'd7;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_int = 32'd5;
    wait_valid(lat, ready_seen);
    check("bp_lat", lat, 31);
    check("bp_res", bus.result, 32'h40E00000);
    held     = bus.result;
    unstable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable = 1'b1;
    end
    check("bp_hold", {31'd0, unstable}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_accept", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    wait_valid(lat, ready_seen);
    check("bp_next_lat", lat, 31);
    check("bp_next_res", bus.result, 32'h40A00000);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of normalisation.
    bus.in_int   = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_result", bus.result, 32'h0);
    check("arst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    check("arst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    convert(32'd3, 32'h40400000, 32, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
